// File: rtl/fsm_trace_checker.sv
// Trace checker for the 4-state A-driven sequencer: flags illegal transitions and
// optionally counts full ring laps when FSM_TRACE_LAP_EN is defined.
module fsm_trace_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_in,
  input  logic [1:0]       z_in,
  input  logic             fsm_rst,
  input  logic             clr,
  output logic             armed,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       err_exp,
  output logic [1:0]       err_got,
  output logic [CNT_W-1:0] lap_fwd_cnt,
  output logic [CNT_W-1:0] lap_rev_cnt
);

  typedef enum logic {UNARMED, ARMED} chk_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_t state, state_nxt;
  logic [1:0] exp_z;
  logic       exp_v;
  logic       mismatch;

  // Ring step: A=1 walks 0->1->2->3->0, A=0 walks the other way.
  function automatic logic [1:0] next_z(input logic [1:0] z, input logic a);
    return a ? z + 2'd1 : z - 2'd1;
  endfunction

  // NOTE: always_comb assigns every output a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    if (fsm_rst) state_nxt = ARMED;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= UNARMED;
    else          state <= state_nxt;
  end

  assign armed    = (state == ARMED);
  assign mismatch = exp_v && (z_in != exp_z);

  // Expectation is always rebuilt from the observed state so checking resyncs after a fault.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_z <= 2'd0;
      exp_v <= 1'b0;
    end else if (fsm_rst) begin
      exp_z <= 2'd0;
      exp_v <= 1'b1;
    end else if (armed) begin
      exp_z <= next_z(z_in, a_in);
    end else begin
      exp_v <= 1'b0;
    end
  end

  // The pulse is independent of clr; counts and captures yield to clr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      err_exp    <= 2'd0;
      err_got    <= 2'd0;
    end else begin
      err <= mismatch;
      if (clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
        err_exp    <= 2'd0;
        err_got    <= 2'd0;
      end else if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
        if (!err_sticky) begin
          err_sticky <= 1'b1;
          err_exp    <= exp_z;
          err_got    <= z_in;
        end
      end
    end
  end

`ifdef FSM_TRACE_LAP_EN
  logic [1:0] prev_z;
  logic [1:0] fwd_run, rev_run;
  logic       fwd_step, rev_step;

  always_comb begin
    fwd_step = (z_in == prev_z + 2'd1);
    rev_step = (z_in == prev_z - 2'd1);
  end

  // A run counts steps taken since leaving s0; the fourth step closes a lap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_z      <= 2'd0;
      fwd_run     <= 2'd0;
      rev_run     <= 2'd0;
      lap_fwd_cnt <= '0;
      lap_rev_cnt <= '0;
    end else begin
      prev_z <= z_in;
      if (fsm_rst || !armed || mismatch) begin
        fwd_run <= 2'd0;
        rev_run <= 2'd0;
      end else begin
        if (fwd_step && (fwd_run != 2'd0 || prev_z == 2'd0)) begin
          fwd_run <= (fwd_run == 2'd3) ? 2'd0 : fwd_run + 2'd1;
          if (fwd_run == 2'd3 && !clr && lap_fwd_cnt != '1)
            lap_fwd_cnt <= lap_fwd_cnt + CNT_ONE;
        end else begin
          fwd_run <= 2'd0;
        end
        if (rev_step && (rev_run != 2'd0 || prev_z == 2'd0)) begin
          rev_run <= (rev_run == 2'd3) ? 2'd0 : rev_run + 2'd1;
          if (rev_run == 2'd3 && !clr && lap_rev_cnt != '1)
            lap_rev_cnt <= lap_rev_cnt + CNT_ONE;
        end else begin
          rev_run <= 2'd0;
        end
      end
      if (clr) begin
        lap_fwd_cnt <= '0;
        lap_rev_cnt <= '0;
      end
    end
  end
`else
  assign lap_fwd_cnt = '0;
  assign lap_rev_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Directed bench for fsm_trace_checker: vector table plus hand sequences for
// saturation, clear and asynchronous reset.
module tb_fsm_trace_checker;

`ifdef FSM_TRACE_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       a_in, fsm_rst, clr;
  logic [1:0] z_in;

  logic       armed, err, err_sticky;
  logic [7:0] err_cnt, lap_fwd_cnt, lap_rev_cnt;
  logic [1:0] err_exp, err_got;

  logic       armed2, err2, err_sticky2;
  logic [1:0] err_cnt2, lap_fwd_cnt2, lap_rev_cnt2;
  logic [1:0] err_exp2, err_got2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fsm_trace_checker dut (
    .clock(clock), .reset_n(reset_n), .a_in(a_in), .z_in(z_in),
    .fsm_rst(fsm_rst), .clr(clr), .armed(armed), .err(err),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .err_exp(err_exp),
    .err_got(err_got), .lap_fwd_cnt(lap_fwd_cnt), .lap_rev_cnt(lap_rev_cnt)
  );

  fsm_trace_checker #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .a_in(a_in), .z_in(z_in),
    .fsm_rst(fsm_rst), .clr(clr), .armed(armed2), .err(err2),
    .err_sticky(err_sticky2), .err_cnt(err_cnt2), .err_exp(err_exp2),
    .err_got(err_got2), .lap_fwd_cnt(lap_fwd_cnt2), .lap_rev_cnt(lap_rev_cnt2)
  );

  typedef struct {
    logic       rst, clr, a;
    logic [1:0] z;
    logic       armed, err, sticky;
    logic [7:0] cnt;
    logic [1:0] eexp, egot;
    logic [7:0] lfwd, lrev;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic c, input logic a, input logic [1:0] z,
                     input logic arm, input logic e, input logic st, input logic [7:0] cnt,
                     input logic [1:0] ee, input logic [1:0] eg,
                     input logic [7:0] lf, input logic [7:0] lr);
    vec_t v;
    v = '{rst: rst, clr: c, a: a, z: z, armed: arm, err: e, sticky: st, cnt: cnt,
          eexp: ee, egot: eg, lfwd: lf, lrev: lr};
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after an edge and are held through the next edge.
  task automatic step(input logic rst, input logic c, input logic a, input logic [1:0] z);
    fsm_rst = rst; clr = c; a_in = a; z_in = z;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".armed"},      32'(armed),       32'd0);
    check({tag, ".err"},        32'(err),         32'd0);
    check({tag, ".err_sticky"}, 32'(err_sticky),  32'd0);
    check({tag, ".err_cnt"},    32'(err_cnt),     32'd0);
    check({tag, ".err_exp"},    32'(err_exp),     32'd0);
    check({tag, ".err_got"},    32'(err_got),     32'd0);
    check({tag, ".lap_fwd"},    32'(lap_fwd_cnt), 32'd0);
    check({tag, ".lap_rev"},    32'(lap_rev_cnt), 32'd0);
  endtask

  initial begin
    logic [1:0] ez;
    string      tag;

    reset_n = 1'b0; fsm_rst = 1'b0; clr = 1'b0; a_in = 1'b0; z_in = 2'd0;
    #1;
    check_all_zero("por");
    #20;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_all_zero("after_reset");

    // Unarmed: random traffic without fsm_rst must never be checked.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      check($sformatf("unarmed[%0d].armed", i), 32'(armed),   32'd0);
      check($sformatf("unarmed[%0d].err", i),   32'(err),     32'd0);
      check($sformatf("unarmed[%0d].cnt", i),   32'(err_cnt), 32'd0);
    end

    //   rst clr a  z   armed err st cnt eexp egot lfwd lrev
    add(1, 0, 1, 3,  1, 0, 0, 0, 0, 0, 0, 0);   // arm
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);   // forward ring
    add(0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 2,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 2,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 3,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 2, 0);
    add(1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0);   // re-arm with clear
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);   // reverse ring
    add(0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 2,  1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 3,  1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 2,  1, 1, 1, 1, 1, 2, 1, 1);   // 2 where 1 expected
    add(0, 0, 1, 3,  1, 0, 1, 1, 1, 2, 1, 1);   // resynced, clean
    add(0, 0, 1, 0,  1, 0, 1, 1, 1, 2, 1, 1);
    add(0, 0, 0, 3,  1, 1, 1, 2, 1, 2, 1, 1);   // two back-to-back mismatches
    add(0, 0, 0, 1,  1, 1, 1, 3, 1, 2, 1, 1);
    add(0, 0, 1, 0,  1, 0, 1, 3, 1, 2, 1, 1);
    add(0, 1, 1, 3,  1, 1, 0, 0, 0, 0, 0, 0);   // clr with mismatch
    add(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3,  1, 1, 1, 1, 1, 3, 0, 0);   // +1 step but mismatch: run cleared
    add(0, 0, 1, 0,  1, 0, 1, 1, 1, 3, 0, 0);   // so no lap here
    add(1, 0, 1, 2,  1, 1, 1, 2, 1, 3, 0, 0);   // fsm_rst with mismatch
    add(0, 0, 1, 0,  1, 0, 1, 2, 1, 3, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].a, vecs[i].z);
      tag = $sformatf("vec[%0d]", i);
      check({tag, ".armed"},   32'(armed),       32'(vecs[i].armed));
      check({tag, ".err"},     32'(err),         32'(vecs[i].err));
      check({tag, ".sticky"},  32'(err_sticky),  32'(vecs[i].sticky));
      check({tag, ".cnt"},     32'(err_cnt),     32'(vecs[i].cnt));
      check({tag, ".err_exp"}, 32'(err_exp),     32'(vecs[i].eexp));
      check({tag, ".err_got"}, 32'(err_got),     32'(vecs[i].egot));
      check({tag, ".lap_fwd"}, 32'(lap_fwd_cnt), LAP_ON ? 32'(vecs[i].lfwd) : 32'd0);
      check({tag, ".lap_rev"}, 32'(lap_rev_cnt), LAP_ON ? 32'(vecs[i].lrev) : 32'd0);
    end

    // Saturation: clear, then five mismatches; the 2-bit instance stops at 3.
    step(1'b0, 1'b1, 1'b1, 2'd1);
    check("sat_clr.cnt",  32'(err_cnt),  32'd0);
    check("sat_clr.cnt2", 32'(err_cnt2), 32'd0);
    ez = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, ez + 2'd2);
      check($sformatf("sat[%0d].err", i), 32'(err), 32'd1);
      ez = ez + 2'd3;
    end
    check("sat.cnt8",    32'(err_cnt),    32'd5);
    check("sat.cnt2",    32'(err_cnt2),   32'd3);
    check("sat.sticky2", 32'(err_sticky2), 32'd1);
    check("sat.err_exp", 32'(err_exp),    32'd2);
    check("sat.err_got", 32'(err_got),    32'd0);
    step(1'b0, 1'b1, 1'b1, ez);
    check("sat_clr2.cnt2",    32'(err_cnt2),    32'd0);
    check("sat_clr2.sticky2", 32'(err_sticky2), 32'd0);
    check("sat_clr2.err",     32'(err),         32'd0);

    // Mismatch, then asynchronous reset between edges.
    step(1'b0, 1'b0, 1'b1, 2'd0);
    check("pre_rst.err",     32'(err),     32'd1);
    check("pre_rst.err_exp", 32'(err_exp), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_rst.armed2", 32'(armed2), 32'd0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      check($sformatf("post_rst[%0d].armed", i), 32'(armed),   32'd0);
      check($sformatf("post_rst[%0d].err", i),   32'(err),     32'd0);
      check($sformatf("post_rst[%0d].cnt", i),   32'(err_cnt), 32'd0);
    end
    step(1'b1, 1'b0, 1'b1, 2'd2);
    check("rearm.armed", 32'(armed), 32'd1);
    step(1'b0, 1'b0, 1'b1, 2'd1);
    check("rearm_bad.err", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_trace_checker.md
# fsm_trace_checker

Downstream monitor for the 4-state A-driven sequencer. It observes the sequencer's input bit and 2-bit state output each clock and checks every transition against the fixed transition table. It reports mismatches as a one-cycle pulse, a saturating count and first-error capture. Optionally, it counts complete forward and reverse laps of the state ring. It sits beside the sequencer in the same clock domain and drives only status outputs.

## Interface
- CNT_W, 8, width of err_cnt and lap counters (≥2)
- clock  input  1  sole clock; all flops sample on posedge
- reset_n  input  1  asynchronous, active-low reset
- a_in  input  1  same A bit driven into the sequencer this cycle
- z_in  input  2  sequencer state output
- fsm_rst  input  1  the sequencer's synchronous reset, tapped at its input
- clr  input  1  synchronous clear of err_cnt, err_sticky, err_exp, err_got and lap counters
- armed  output  1  checker is tracking a known state
- err  output  1  one-cycle mismatch pulse
- err_sticky  output  1  set on first mismatch; held until clr
- err_cnt  output  CNT_W  mismatches, saturating at all-ones
- err_exp  output  2  expected state at the first mismatch
- err_got  output  2  observed state at the first mismatch
- lap_fwd_cnt  output  CNT_W  completed forward laps, saturating
- lap_rev_cnt  output  CNT_W  completed reverse laps, saturating

## Operation
- Transition table, next(z,a):
  - a=1: 0→1, 1→2, 2→3, 3→0.
  - a=0: 0→3, 1→0, 2→1, 3→2.
- Checker states:
  - UNARMED (reset): no checking; the sequencer state is unknown. Moves to ARMED on any edge with fsm_rst=1.
  - ARMED: checking active. Stays ARMED; a further fsm_rst re-arms.
- Registers exp_z[1:0] and exp_v, updated on each posedge:
  - fsm_rst=1: exp_z←0, exp_v←1.
  - else if armed: exp_z←next(z_in,a_in).
  - else: exp_v←0.
- Mismatch: exp_v=1 and z_in≠exp_z in the current cycle.
- Resync: exp_z is always derived from the observed z_in, never from exp_z. After a fault, checking continues from the actual state.
- On mismatch:
  - err=1 on the next cycle.
  - err_cnt increments (saturating).
  - If err_sticky=0: err_sticky←1, err_exp←exp_z, err_got←z_in.
- Lap tracking (armed only). Each observed transition prev_z→z_in is classed as +1, −1 or other:
  - fwd_run (0..3) increments on a +1 transition when fwd_run>0 or prev_z=0. On any other transition it returns to 0.
  - When fwd_run=3 and a +1 transition lands on s0, lap_fwd_cnt increments and fwd_run←0, so the landing s0 starts the next lap.
  - rev_run mirrors fwd_run using −1 transitions and updates lap_rev_cnt.
  - A mismatch cycle clears both runs. fsm_rst clears both runs but not the counts.
- Simultaneous events:
  - clr together with a mismatch: the clear wins for counts and sticky, but the err pulse still fires.
  - fsm_rst together with a mismatch: the mismatch is still reported, then the checker re-arms.

## Timing
- Async reset (reset_n=0) sets all outputs to 0, state UNARMED and exp_v=0, immediately and independent of clock.
- z_in is checked in the cycle it is presented; err, err_cnt and the captures update at the following posedge. Latency is one cycle.
- A lap count updates one cycle after z_in shows the closing s0.
- The first checked cycle is the one after the edge where fsm_rst=1; it must show z_in=0.
- err is never asserted for two cycles unless two consecutive mismatches occur.

## Configuration
- FSM_TRACE_LAP_EN defined: the lap tracker, fwd_run/rev_run, lap_fwd_cnt and lap_rev_cnt are built as described.
- FSM_TRACE_LAP_EN undefined: the lap logic is removed, and lap_fwd_cnt and lap_rev_cnt are tied to 0. Error checking is unchanged.

## Test plan
- Stimulus: random z_in/a_in for 20 cycles with no fsm_rst. Required: armed=0, err never asserts, err_cnt=0.
- Stimulus: fsm_rst for 1 cycle, then a_in=1 for 8 cycles (z 0,1,2,3,0,1,2,3,0). Required: lap_fwd_cnt=2, err_cnt=0 (macro on).
- Stimulus: fsm_rst, then a_in=0 for 4 cycles (z 0,3,2,1,0), then a_in=1 once. Required: lap_rev_cnt=1, lap_fwd_cnt=0.
- Stimulus: armed at z=0 with a_in=1; force z_in=2 where 1 is expected. Required: err pulses one cycle later, err_exp=1, err_got=2, err_cnt=1, err_sticky=1. The next correct transition from 2 gives no error.
- Stimulus: CNT_W=2, inject 5 mismatches. Required: err_cnt saturates at 3. Then clr: err_cnt=0, err_sticky=0.
- Stimulus: assert reset_n=0 mid-lap, between clock edges. Required: all outputs 0 without a clock edge, armed=0. After release, no checking until fsm_rst.
